pll_ref_ctrl: RTL and testbench
===============================

PLL_REF_CTRL -- requirements
Module: pll_ref_ctrl

Interface
REQ-001 SHALL have parameter CNT_W, default 21, width of the period counter in clk cycles.
REQ-002 SHALL have parameter PER_NOM, default 102400, nominal clk cycles between reference toggles.
REQ-003 SHALL have parameter PER_TOL, default 15, accepted deviation from PER_NOM; the check is exclusive at both limits.
REQ-004 SHALL have parameter VAL_N, default 2, number of consecutive valid periods required before enabling the PLL.
REQ-005 SHALL have parameter LCK_TMO, default 4, number of periods allowed for lock to appear.
REQ-006 SHALL have parameter HOLD_CYC, default 1000, clk cycles spent in back-off after a failure.
REQ-007 clk  input  1  system clock; the block uses this single clock only.
REQ-008 rst  input  1  reset; asynchronous assert, active-high.
REQ-009 cfg_en  input  1  software enable for PLL control.
REQ-010 ref_tgl  input  1  divided reference bit, already synchronized to clk.
REQ-011 lck_raw  input  1  per-period phase-lock indication, level, clk domain.
REQ-012 pll_en  output  1  enables the phase detector drive (lo/hi outputs).
REQ-013 ref_val  output  1  result of the most recent period check.
REQ-014 pll_lck  output  1  high while the block is in LOCK.
REQ-015 state  output  3  current FSM encoding: IDLE=0, MEAS=1, WAIT=2, LOCK=3, HOLD=4.
REQ-016 fail_cnt  output  8  count of failures, saturating.

Function
REQ-017 SHALL register ref_tgl into tgl_q; edge SHALL be (ref_tgl XOR tgl_q).
REQ-018 Period counter, on edge: SHALL load 1.
REQ-019 Period counter, otherwise: SHALL increment while bit CNT_W-1 is clear and hold once that bit is set.
REQ-020 tmo SHALL be a single-cycle pulse on the cycle the period counter sets bit CNT_W-1.
REQ-021 pv SHALL be a combinational term, true on an edge when PER_NOM-PER_TOL < counter < PER_NOM+PER_TOL.
REQ-022 ref_val SHALL load pv on each edge, clear on tmo, and hold otherwise.
REQ-023 bad SHALL be the event (edge AND NOT pv) OR tmo.
REQ-024 Priority SHALL be: rst, then cfg_en=0, then the FSM transitions below.
REQ-025 cfg_en=0 in any state SHALL force IDLE on the next clk, with pll_en=0 and counters vcnt/gcnt/hcnt cleared.
REQ-026 IDLE: pll_en=0. When cfg_en=1 the FSM SHALL go to MEAS with vcnt=0.
REQ-027 MEAS: pll_en=0. On edge with pv, vcnt++; when vcnt reaches VAL_N the FSM SHALL go to WAIT with gcnt=0. On bad, vcnt=0 and the FSM stays in MEAS. A failure is not counted in MEAS.
REQ-028 WAIT: pll_en=1. On edge with pv and lck_raw=1 the FSM SHALL go to LOCK.
REQ-029 WAIT: on edge with pv and lck_raw=0, gcnt++; when gcnt reaches LCK_TMO the FSM SHALL go to HOLD and count a failure.
REQ-030 WAIT: on bad the FSM SHALL go to HOLD and count a failure.
REQ-031 LOCK: pll_en=1, pll_lck=1. On bad, or on edge with lck_raw=0, the FSM SHALL go to HOLD and count a failure.
REQ-032 HOLD: pll_en=0, hcnt counts clk cycles from 0; at hcnt=HOLD_CYC-1 the FSM SHALL go to MEAS with vcnt=0. Edges are ignored in HOLD.
REQ-033 fail_cnt SHALL increment by 1 per failure, saturate at 255, and clear only on rst.
REQ-034 pll_en, pll_lck and state SHALL be registered outputs, valid the same cycle the state register updates.
REQ-035 Latency: a qualifying edge at cycle N SHALL produce the new state and outputs at cycle N+1.

Reset
REQ-036 On rst: state=IDLE, pll_en=0, pll_lck=0, ref_val=0, fail_cnt=0, counters cleared, period counter=0, tgl_q=0.
REQ-037 Release of rst SHALL have no side effect other than normal operation starting on the next clk edge.

Verification
REQ-038 ref_tgl period 102400 clk, cfg_en=1, lck_raw=1 -> MEAS, then WAIT after the 2nd valid edge, LOCK on the next edge; pll_en=1, pll_lck=1, fail_cnt=0.
REQ-039 Period 102415 (boundary), then 102414 -> ref_val=0 for 102415; ref_val=1 for 102414; the 102385 boundary rejected and 102386 accepted.
REQ-040 ref_tgl stalls while in LOCK -> tmo after 2^20 cycles, HOLD, pll_en=0, fail_cnt=1; MEAS after 1000 cycles.
REQ-041 lck_raw=0 held in WAIT -> HOLD after 4 valid edges, fail_cnt=1; repeated failures -> fail_cnt stops at 255.
REQ-042 cfg_en dropped on the same cycle as a locking edge in WAIT -> IDLE, pll_en=0, pll_lck never asserted.
REQ-043 rst asserted mid-LOCK -> all outputs 0 asynchronously, fail_cnt=0; the sequence restarts after release.

Source files
------------

// File: rtl/pll_ref_if.sv
// Control/status bundle between a supervisor and the PLL reference controller.
interface pll_ref_if;
  logic       cfg_en;
  logic       ref_tgl;
  logic       lck_raw;
  logic       pll_en;
  logic       ref_val;
  logic       pll_lck;
  logic [2:0] state;
  logic [7:0] fail_cnt;

  modport master (
    output cfg_en, ref_tgl, lck_raw,
    input  pll_en, ref_val, pll_lck, state, fail_cnt
  );

  modport slave (
    input  cfg_en, ref_tgl, lck_raw,
    output pll_en, ref_val, pll_lck, state, fail_cnt
  );
endinterface

// File: rtl/pll_ref_ctrl.sv
// PLL reference controller: measures the divided reference period, qualifies
// it, enables the PLL after stable periods, watches for lock and backs off on
// failure.
module pll_ref_ctrl #(
  parameter int CNT_W    = 21,
  parameter int PER_NOM  = 102400,
  parameter int PER_TOL  = 15,
  parameter int VAL_N    = 2,
  parameter int LCK_TMO  = 4,
  parameter int HOLD_CYC = 1000
) (
  input logic     clk,
  input logic     rst,
  pll_ref_if.slave bus
);

  localparam int VW = $clog2(VAL_N + 1);
  localparam int GW = $clog2(LCK_TMO + 1);
  localparam int HW = $clog2(HOLD_CYC + 1);

  localparam logic [CNT_W-1:0] PER_LO   = CNT_W'(PER_NOM - PER_TOL);
  localparam logic [CNT_W-1:0] PER_HI   = CNT_W'(PER_NOM + PER_TOL);
  // Counter value one below the point where the top bit sets.
  localparam logic [CNT_W-1:0] TMO_PRE  = {1'b0, {(CNT_W-1){1'b1}}};
  localparam logic [VW-1:0]    VAL_LAST = VW'(VAL_N - 1);
  localparam logic [GW-1:0]    GCN_LAST = GW'(LCK_TMO - 1);
  localparam logic [HW-1:0]    HLD_LAST = HW'(HOLD_CYC - 1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_MEAS = 3'd1,
    S_WAIT = 3'd2,
    S_LOCK = 3'd3,
    S_HOLD = 3'd4
  } state_t;

  state_t           state_q;
  logic             tgl_q;
  logic [CNT_W-1:0] per_cnt_q;
  logic             ref_val_q;
  logic             pll_en_q;
  logic             pll_lck_q;
  logic [VW-1:0]    vcnt_q;
  logic [GW-1:0]    gcnt_q;
  logic [HW-1:0]    hcnt_q;
  logic [7:0]       fail_cnt_q;

  logic edge_det;
  logic pv;
  logic tmo;
  logic bad;
  logic fail_evt;

  assign edge_det = bus.ref_tgl ^ tgl_q;
  assign pv       = edge_det && (per_cnt_q > PER_LO) && (per_cnt_q < PER_HI);
  // Fires on the cycle the counter rolls into its saturated top bit.
  assign tmo      = !edge_det && (per_cnt_q == TMO_PRE);
  assign bad      = (edge_det && !pv) || tmo;

  // A failure is only counted while enabled, in WAIT or LOCK.
  always_comb begin
    fail_evt = 1'b0;
    if (bus.cfg_en) begin
      if (state_q == S_WAIT)
        fail_evt = bad || (pv && !bus.lck_raw && gcnt_q == GCN_LAST);
      else if (state_q == S_LOCK)
        fail_evt = bad || (edge_det && !bus.lck_raw);
    end
  end

  // Reference edge detect and period counter (saturates on its top bit).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tgl_q     <= 1'b0;
      per_cnt_q <= '0;
    end else begin
      tgl_q <= bus.ref_tgl;
      if (edge_det)
        per_cnt_q <= CNT_W'(1);
      else if (!per_cnt_q[CNT_W-1])
        per_cnt_q <= per_cnt_q + CNT_W'(1);
    end
  end

  // Result of the latest period check; a timeout invalidates it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      ref_val_q <= 1'b0;
    else if (edge_det)
      ref_val_q <= pv;
    else if (tmo)
      ref_val_q <= 1'b0;
  end

  // Saturating failure counter, cleared only by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      fail_cnt_q <= 8'd0;
    else if (fail_evt && fail_cnt_q != 8'hFF)
      fail_cnt_q <= fail_cnt_q + 8'd1;
  end

  // Control FSM with registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      pll_en_q  <= 1'b0;
      pll_lck_q <= 1'b0;
      vcnt_q    <= '0;
      gcnt_q    <= '0;
      hcnt_q    <= '0;
    end else if (!bus.cfg_en) begin
      state_q   <= S_IDLE;
      pll_en_q  <= 1'b0;
      pll_lck_q <= 1'b0;
      vcnt_q    <= '0;
      gcnt_q    <= '0;
      hcnt_q    <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          state_q <= S_MEAS;
          vcnt_q  <= '0;
        end
        S_MEAS: begin
          if (pv) begin
            if (vcnt_q == VAL_LAST) begin
              state_q  <= S_WAIT;
              pll_en_q <= 1'b1;
              gcnt_q   <= '0;
            end else begin
              vcnt_q <= vcnt_q + VW'(1);
            end
          end else if (bad) begin
            vcnt_q <= '0;
          end
        end
        S_WAIT: begin
          if (pv && bus.lck_raw) begin
            state_q   <= S_LOCK;
            pll_lck_q <= 1'b1;
          end else if (fail_evt) begin
            state_q  <= S_HOLD;
            pll_en_q <= 1'b0;
            hcnt_q   <= '0;
          end else if (pv) begin
            gcnt_q <= gcnt_q + GW'(1);
          end
        end
        S_LOCK: begin
          if (fail_evt) begin
            state_q   <= S_HOLD;
            pll_en_q  <= 1'b0;
            pll_lck_q <= 1'b0;
            hcnt_q    <= '0;
          end
        end
        S_HOLD: begin
          if (hcnt_q == HLD_LAST) begin
            state_q <= S_MEAS;
            vcnt_q  <= '0;
            hcnt_q  <= '0;
          end else begin
            hcnt_q <= hcnt_q + HW'(1);
          end
        end
        default: begin
          state_q   <= S_IDLE;
          pll_en_q  <= 1'b0;
          pll_lck_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.pll_en   = pll_en_q;
  assign bus.pll_lck  = pll_lck_q;
  assign bus.ref_val  = ref_val_q;
  assign bus.state    = state_q;
  assign bus.fail_cnt = fail_cnt_q;

endmodule

// File: tb/tb_pll_ref_ctrl.sv
// Directed bench for pll_ref_ctrl with shrunk parameters:
// nominal period 40, accepted 38..42, timeout 127 cycles after an edge,
// hold 20 cycles.
module tb_pll_ref_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;

  pll_ref_if bus ();

  pll_ref_ctrl #(
    .CNT_W   (8),
    .PER_NOM (40),
    .PER_TOL (3),
    .VAL_N   (2),
    .LCK_TMO (4),
    .HOLD_CYC(20)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance n clock edges; outputs are sampled 1 time unit after each edge.
  task automatic wait_cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Toggle the reference so the next clock edge sees a reference edge.
  task automatic tgl_edge();
    bus.ref_tgl = ~bus.ref_tgl;
    wait_cyc(1);
  endtask

  // Reference edge exactly p clocks after the previous one.
  task automatic period(input int p);
    wait_cyc(p - 1);
    tgl_edge();
  endtask

  // Starts in MEAS 20 cycles after the last edge; ends the same way after
  // one counted failure (bad short period while in WAIT).
  task automatic fail_round();
    wait_cyc(19);
    tgl_edge();
    period(40);
    period(10);
    wait_cyc(20);
  endtask

  initial begin
    bus.cfg_en  = 1'b0;
    bus.ref_tgl = 1'b0;
    bus.lck_raw = 1'b0;

    // Reset state
    wait_cyc(3);
    chk("rst_state", 32'(bus.state), 32'd0);
    chk("rst_pll_en", 32'(bus.pll_en), 32'd0);
    chk("rst_pll_lck", 32'(bus.pll_lck), 32'd0);
    chk("rst_ref_val", 32'(bus.ref_val), 32'd0);
    chk("rst_fail_cnt", 32'(bus.fail_cnt), 32'd0);
    rst = 1'b0;

    // Disabled: an edge does not leave IDLE
    tgl_edge();
    chk("idle_disabled", 32'(bus.state), 32'd0);
    bus.cfg_en = 1'b1;
    wait_cyc(1);
    chk("idle_to_meas", 32'(bus.state), 32'd1);

    // Two nominal periods -> WAIT, then locking edge -> LOCK
    wait_cyc(38);
    tgl_edge();
    chk("meas_v1_state", 32'(bus.state), 32'd1);
    chk("meas_v1_ref_val", 32'(bus.ref_val), 32'd1);
    period(40);
    chk("wait_state", 32'(bus.state), 32'd2);
    chk("wait_pll_en", 32'(bus.pll_en), 32'd1);
    chk("wait_pll_lck", 32'(bus.pll_lck), 32'd0);
    bus.lck_raw = 1'b1;
    period(40);
    chk("lock_state", 32'(bus.state), 32'd3);
    chk("lock_pll_en", 32'(bus.pll_en), 32'd1);
    chk("lock_pll_lck", 32'(bus.pll_lck), 32'd1);
    chk("lock_fail_cnt", 32'(bus.fail_cnt), 32'd0);

    // Upper boundary 43 rejected while locked -> HOLD with a failure
    period(43);
    chk("hi_bound_ref_val", 32'(bus.ref_val), 32'd0);
    chk("hi_bound_state", 32'(bus.state), 32'd4);
    chk("hi_bound_pll_en", 32'(bus.pll_en), 32'd0);
    chk("hi_bound_fail", 32'(bus.fail_cnt), 32'd1);

    // HOLD lasts exactly 20 cycles
    wait_cyc(19);
    chk("hold_last", 32'(bus.state), 32'd4);
    wait_cyc(1);
    chk("hold_to_meas", 32'(bus.state), 32'd1);

    // Period limits in MEAS: 42 ok, 37 rejected, 38 ok
    wait_cyc(21);
    tgl_edge();
    chk("per42_ref_val", 32'(bus.ref_val), 32'd1);
    period(37);
    chk("per37_ref_val", 32'(bus.ref_val), 32'd0);
    chk("per37_state", 32'(bus.state), 32'd1);
    period(38);
    chk("per38_ref_val", 32'(bus.ref_val), 32'd1);
    chk("per38_state", 32'(bus.state), 32'd1);
    period(40);
    chk("meas_to_wait", 32'(bus.state), 32'd2);

    // No lock for LCK_TMO valid periods -> HOLD
    bus.lck_raw = 1'b0;
    period(40);
    period(40);
    period(40);
    chk("gcnt3_state", 32'(bus.state), 32'd2);
    period(40);
    chk("gcnt4_state", 32'(bus.state), 32'd4);
    chk("gcnt4_fail", 32'(bus.fail_cnt), 32'd2);
    wait_cyc(20);
    chk("hold2_to_meas", 32'(bus.state), 32'd1);

    // Lock then stall the reference -> timeout 127 cycles after last edge
    bus.lck_raw = 1'b1;
    wait_cyc(19);
    tgl_edge();
    period(40);
    period(40);
    chk("lock2_state", 32'(bus.state), 32'd3);
    wait_cyc(126);
    chk("pre_tmo_state", 32'(bus.state), 32'd3);
    chk("pre_tmo_ref_val", 32'(bus.ref_val), 32'd1);
    wait_cyc(1);
    chk("tmo_state", 32'(bus.state), 32'd4);
    chk("tmo_pll_en", 32'(bus.pll_en), 32'd0);
    chk("tmo_ref_val", 32'(bus.ref_val), 32'd0);
    chk("tmo_fail", 32'(bus.fail_cnt), 32'd3);
    wait_cyc(20);
    chk("hold3_to_meas", 32'(bus.state), 32'd1);

    // cfg_en dropped on the locking edge in WAIT -> IDLE, never locked
    tgl_edge();
    chk("sat_cnt_edge_state", 32'(bus.state), 32'd1);
    period(40);
    period(40);
    chk("wait3_state", 32'(bus.state), 32'd2);
    wait_cyc(39);
    bus.cfg_en = 1'b0;
    tgl_edge();
    chk("drop_state", 32'(bus.state), 32'd0);
    chk("drop_pll_en", 32'(bus.pll_en), 32'd0);
    chk("drop_pll_lck", 32'(bus.pll_lck), 32'd0);
    chk("drop_fail", 32'(bus.fail_cnt), 32'd3);
    wait_cyc(1);
    chk("drop_pll_lck_after", 32'(bus.pll_lck), 32'd0);
    bus.cfg_en = 1'b1;
    wait_cyc(19);
    chk("reenable_state", 32'(bus.state), 32'd1);

    // Repeated failures saturate the failure counter
    for (int i = 0; i < 252; i++) fail_round();
    chk("fail_255", 32'(bus.fail_cnt), 32'd255);
    fail_round();
    chk("fail_sat", 32'(bus.fail_cnt), 32'd255);
    chk("fail_sat_state", 32'(bus.state), 32'd1);

    // Asynchronous reset in the middle of LOCK
    wait_cyc(19);
    tgl_edge();
    period(40);
    period(40);
    chk("lock3_state", 32'(bus.state), 32'd3);
    #2;
    rst = 1'b1;
    bus.ref_tgl = 1'b0;
    #1;
    chk("arst_state", 32'(bus.state), 32'd0);
    chk("arst_pll_en", 32'(bus.pll_en), 32'd0);
    chk("arst_pll_lck", 32'(bus.pll_lck), 32'd0);
    chk("arst_ref_val", 32'(bus.ref_val), 32'd0);
    chk("arst_fail", 32'(bus.fail_cnt), 32'd0);
    wait_cyc(2);
    rst = 1'b0;
    wait_cyc(1);
    chk("restart_meas", 32'(bus.state), 32'd1);
    tgl_edge();
    period(40);
    period(40);
    chk("restart_wait", 32'(bus.state), 32'd2);
    chk("restart_fail", 32'(bus.fail_cnt), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
